// File: rtl/matriz_ctrl.sv
// Sequencer for the 5x5 int8 matrix coprocessor: row fetch, exec, row store.
// Optional EXEC watchdog enabled with `define MATRIZ_CTRL_TIMEOUT_EN.
module matriz_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_addr_a,
  input  logic [ADDR_W-1:0] instr_addr_b,
  input  logic [ADDR_W-1:0] instr_addr_c,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [39:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [39:0]       mem_wdata,
  output logic [2:0]        op_sel,
  output logic              op_start,
  output logic [199:0]      op_a,
  output logic [199:0]      op_b,
  input  logic [199:0]      op_result,
  input  logic              op_done,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    STORE,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        row, row_nx;
  logic [ADDR_W-1:0] addr_a, addr_b, addr_c;
  logic [199:0]      res;
  logic              accept;
  logic              take;

`ifdef MATRIZ_CTRL_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        tmo;
  logic        err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      row    <= '0;
      op_sel <= '0;
      addr_a <= '0;
      addr_b <= '0;
      addr_c <= '0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      if (accept) begin
        op_sel <= instr_op;
        addr_a <= instr_addr_a;
        addr_b <= instr_addr_b;
        addr_c <= instr_addr_c;
      end
      // read data lags the address by one cycle, so row r lands at r+1
      if (state == LOAD_A && row != 3'd0)
        op_a[40*(int'(row)-1) +: 40] <= mem_rdata;
      if (state == LOAD_B && row != 3'd0)
        op_b[40*(int'(row)-1) +: 40] <= mem_rdata;
      if (take)
        res <= op_result;
    end
  end

`ifdef MATRIZ_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= (state == EXEC) ? tcnt + 16'd1 : '0;
      if (accept)
        err <= 1'b0;
      else if (tmo)
        err <= 1'b1;
    end
  end

  assign error = err;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    row_nx      = row;
    instr_ready = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wdata   = '0;
    op_start    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    accept      = 1'b0;
    take        = 1'b0;
`ifdef MATRIZ_CTRL_TIMEOUT_EN
    tmo         = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        busy        = 1'b0;
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept   = 1'b1;
          state_nx = LOAD_A;
          row_nx   = '0;
        end
      end
      LOAD_A: begin
        if (row != 3'd5) begin
          mem_rd_en = 1'b1;
          mem_addr  = addr_a + ADDR_W'(row);
          row_nx    = row + 3'd1;
        end else begin
          row_nx   = '0;
          state_nx = op_sel[2] ? EXEC : LOAD_B;
        end
      end
      LOAD_B: begin
        if (row != 3'd5) begin
          mem_rd_en = 1'b1;
          mem_addr  = addr_b + ADDR_W'(row);
          row_nx    = row + 3'd1;
        end else begin
          row_nx   = '0;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        op_start = 1'b1;
        // row doubles as a "past first cycle" flag so a stale done is skipped
        row_nx   = 3'd1;
        if (row != 3'd0 && op_done) begin
          take     = 1'b1;
          state_nx = STORE;
          row_nx   = '0;
        end
`ifdef MATRIZ_CTRL_TIMEOUT_EN
        else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
          tmo      = 1'b1;
          state_nx = DONE;
          row_nx   = '0;
        end
`endif
      end
      STORE: begin
        mem_wr_en = 1'b1;
        mem_addr  = addr_c + ADDR_W'(row);
        mem_wdata = res[40*int'(row) +: 40];
        if (row == 3'd4) begin
          row_nx   = '0;
          state_nx = DONE;
        end else begin
          row_nx = row + 3'd1;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        row_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_matriz_ctrl.sv
// Scoreboard bench for matriz_ctrl: memory and op-unit models,
// expected bus events queued by stimulus and popped by a negedge monitor.
module tb_matriz_ctrl;

  localparam int EV_ACC = 0;
  localparam int EV_RD  = 1;
  localparam int EV_WR  = 2;
  localparam int EV_ST  = 3;
  localparam int EV_DN  = 4;

  typedef struct {
    int          kind;
    logic [9:0]  addr;
    logic [39:0] data;
    int          rel;
  } ev_t;

  logic         clk;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   instr_op;
  logic [9:0]   instr_addr_a;
  logic [9:0]   instr_addr_b;
  logic [9:0]   instr_addr_c;
  logic [9:0]   mem_addr;
  logic         mem_rd_en;
  logic [39:0]  mem_rdata;
  logic         mem_wr_en;
  logic [39:0]  mem_wdata;
  logic [2:0]   op_sel;
  logic         op_start;
  logic [199:0] op_a;
  logic [199:0] op_b;
  logic [199:0] op_result;
  logic         op_done;
  logic         busy;
  logic         done;
  logic         error;

  logic [39:0]  mem [1024];
  ev_t          q[$];
  int           vec = 0;
  int           fail = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           n_acc = 0;
  int           scnt = 0;
  int           lat = 5;
  logic         force_done = 1'b0;
  logic         start_q = 1'b0;

  localparam logic [199:0] ID_M = {
    40'h01_00_00_00_00, 40'h00_01_00_00_00, 40'h00_00_01_00_00,
    40'h00_00_00_01_00, 40'h00_00_00_00_01};
  localparam logic [199:0] B_M = {
    40'h19_18_17_16_15, 40'h14_13_12_11_10, 40'h0F_0E_0D_0C_0B,
    40'h0A_09_08_07_06, 40'h05_04_03_02_01};
  localparam logic [199:0] W_M = {
    40'h55_55_55_55_55, 40'h44_44_44_44_44, 40'h33_33_33_33_33,
    40'h22_22_22_22_22, 40'h11_11_11_11_11};

  matriz_ctrl #(
    .ADDR_W(10),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op(instr_op),
    .instr_addr_a(instr_addr_a),
    .instr_addr_b(instr_addr_b),
    .instr_addr_c(instr_addr_c),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .op_sel(op_sel),
    .op_start(op_start),
    .op_a(op_a),
    .op_b(op_b),
    .op_result(op_result),
    .op_done(op_done),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    scnt <= op_start ? scnt + 1 : 0;
  end

  function automatic logic [199:0] matmul(input logic [199:0] a,
                                          input logic [199:0] b);
    logic [199:0] m;
    logic [7:0]   s;
    m = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        s = '0;
        for (int k = 0; k < 5; k++)
          s = s + a[8*(k+5*r) +: 8] * b[8*(c+5*k) +: 8];
        m[8*(c+5*r) +: 8] = s;
      end
    return m;
  endfunction

  assign op_done   = force_done || (op_start && scnt == lat);
  assign op_result = op_sel[2] ? op_a : matmul(op_a, op_b);

  task automatic chk(input int kind, input logic [9:0] addr,
                     input logic [39:0] data);
    ev_t e;
    int  rel;
    rel = cyc - acc_cyc;
    vec++;
    if (q.size() == 0) begin
      fail++;
      $display("FAIL sb_unexpected got kind=%0d addr=%h data=%h rel=%0d required=none",
               kind, addr, data, rel);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind ||
        ((kind == EV_RD || kind == EV_WR) && e.addr != addr) ||
        (kind == EV_WR && e.data != data) ||
        (e.rel >= 0 && e.rel != rel)) begin
      fail++;
      $display("FAIL sb_event got kind=%0d addr=%h data=%h rel=%0d required kind=%0d addr=%h data=%h rel=%0d",
               kind, addr, data, rel, e.kind, e.addr, e.data, e.rel);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && instr_ready) begin
        chk(EV_ACC, '0, '0);
        acc_cyc = cyc;
        n_acc++;
      end
      if (mem_rd_en) chk(EV_RD, mem_addr, '0);
      if (mem_wr_en) chk(EV_WR, mem_addr, mem_wdata);
      if (op_start && !start_q) chk(EV_ST, '0, '0);
      if (done) chk(EV_DN, '0, '0);
      vec++;
      if (instr_ready == busy || (mem_rd_en && mem_wr_en)) begin
        fail++;
        $display("FAIL ready_busy got ready=%b busy=%b rd=%b wr=%b required ready=!busy, not rd&wr",
                 instr_ready, busy, mem_rd_en, mem_wr_en);
      end
      start_q = op_start;
    end else begin
      start_q = 1'b0;
    end
  end

  task automatic push(input int kind, input logic [9:0] addr,
                      input logic [39:0] data, input int rel);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.rel  = rel;
    q.push_back(e);
  endtask

  task automatic push_rd(input logic [9:0] base, input int rel0);
    for (int i = 0; i < 5; i++)
      push(EV_RD, base + 10'(i), '0, rel0 + i);
  endtask

  task automatic push_wr(input logic [9:0] base, input int rel0,
                         input logic [199:0] m);
    for (int i = 0; i < 5; i++)
      push(EV_WR, base + 10'(i), m[40*i +: 40], rel0 + i);
  endtask

  task automatic check(input string name, input logic [199:0] got,
                       input logic [199:0] exp);
    vec++;
    if (got !== exp) begin
      fail++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [9:0] a,
                       input logic [9:0] b, input logic [9:0] c);
    int n0;
    n0 = n_acc;
    @(posedge clk);
    #1;
    instr_op     = op;
    instr_addr_a = a;
    instr_addr_b = b;
    instr_addr_c = c;
    instr_valid  = 1'b1;
    for (int i = 0; i < 50 && n_acc == n0; i++)
      @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("accept", 200'(n_acc), 200'(n0 + 1));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!busy && q.size() == 0) begin
        vec++;
        return;
      end
    end
    vec++;
    fail++;
    $display("FAIL %s_timeout got busy=%b pending=%0d required busy=0 pending=0",
             name, busy, q.size());
    q.delete();
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 5; i++) begin
      mem[10'h010 + i] = ID_M[40*i +: 40];
      mem[10'h020 + i] = B_M[40*i +: 40];
    end
    mem[10'h3FE] = W_M[39:0];
    mem[10'h3FF] = W_M[79:40];
    mem[10'h000] = W_M[119:80];
    mem[10'h001] = W_M[159:120];
    mem[10'h002] = W_M[199:160];
    mem_rdata    = '0;
    instr_valid  = 1'b0;
    instr_op     = '0;
    instr_addr_a = '0;
    instr_addr_b = '0;
    instr_addr_c = '0;
    rst_n        = 1'b0;
    #23;
    check("rst_ready", 200'(instr_ready), 200'(1));
    check("rst_outs", 200'({busy, done, error, mem_rd_en, mem_wr_en, op_start}),
          200'(0));
    check("rst_op_a", op_a, '0);
    check("rst_op_b", op_b, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    push(EV_ACC, '0, '0, -1);
    push_rd(10'h010, 1);
    push_rd(10'h020, 7);
    push(EV_ST, '0, '0, 13);
    push_wr(10'h030, 19, B_M);
    push(EV_DN, '0, '0, 24);
    issue(3'b000, 10'h010, 10'h020, 10'h030);
    wait_idle("binary");

    push(EV_ACC, '0, '0, -1);
    push_rd(10'h3FE, 1);
    push(EV_ST, '0, '0, 7);
    push_wr(10'h100, 13, W_M);
    push(EV_DN, '0, '0, 18);
    issue(3'b100, 10'h3FE, 10'h3A0, 10'h100);
    wait_idle("unary_wrap");
    check("unary_keeps_b", op_b, B_M);

    force_done = 1'b1;
    push(EV_ACC, '0, '0, -1);
    push_rd(10'h010, 1);
    push(EV_ST, '0, '0, 7);
    push_wr(10'h200, 9, ID_M);
    push(EV_DN, '0, '0, 14);
    issue(3'b100, 10'h010, 10'h020, 10'h200);
    wait_idle("stale_done");
    force_done = 1'b0;

    n0 = n_acc;
    for (int k = 0; k < 2; k++) begin
      push(EV_ACC, '0, '0, (k == 0) ? -1 : 25);
      push_rd(10'h010, 1);
      push_rd(10'h020, 7);
      push(EV_ST, '0, '0, 13);
      push_wr(10'h030, 19, B_M);
      push(EV_DN, '0, '0, 24);
    end
    @(posedge clk);
    #1;
    instr_op     = 3'b000;
    instr_addr_a = 10'h010;
    instr_addr_b = 10'h020;
    instr_addr_c = 10'h030;
    instr_valid  = 1'b1;
    for (int i = 0; i < 100 && n_acc < n0 + 2; i++)
      @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("b2b_accepts", 200'(n_acc), 200'(n0 + 2));
    wait_idle("b2b");

    push(EV_ACC, '0, '0, -1);
    push_rd(10'h010, 1);
    push_rd(10'h020, 7);
    push(EV_ST, '0, '0, 13);
    push(EV_WR, 10'h030, B_M[39:0], 19);
    push(EV_WR, 10'h031, B_M[79:40], 20);
    issue(3'b000, 10'h010, 10'h020, 10'h030);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (mem_wr_en && mem_addr == 10'h032) break;
    end
    check("store_row2_seen", 200'({mem_wr_en, mem_addr}), 200'({1'b1, 10'h032}));
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr", 200'(mem_wr_en), 200'(0));
    check("mid_rst_ready", 200'({instr_ready, busy, done, op_start}),
          200'(4'b1000));
    check("mid_rst_op_a", op_a, '0);
    check("mid_rst_pending", 200'(q.size()), 200'(0));
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

`ifdef MATRIZ_CTRL_TIMEOUT_EN
    lat = 1000;
    push(EV_ACC, '0, '0, -1);
    push_rd(10'h010, 1);
    push(EV_ST, '0, '0, 7);
    push(EV_DN, '0, '0, 15);
    issue(3'b100, 10'h010, 10'h020, 10'h300);
    wait_idle("timeout");
    check("timeout_error", 200'(error), 200'(1));
    lat = 5;
    push(EV_ACC, '0, '0, -1);
    push_rd(10'h010, 1);
    push(EV_ST, '0, '0, 7);
    push_wr(10'h300, 13, ID_M);
    push(EV_DN, '0, '0, 18);
    issue(3'b100, 10'h010, 10'h020, 10'h300);
    check("error_cleared", 200'(error), 200'(0));
    wait_idle("after_timeout");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end

endmodule
